// File: rtl/byte_wb_ctrl_pkg.sv
//------------------------------------------------------------------------------
// byte_wb_pkg
// Shared types and constants for the byte-stream to Wishbone controller:
// Wishbone request/response structs, FSM state encoding, command byte layout
// and the default error byte returned by a timed-out read.
//------------------------------------------------------------------------------
package byte_wb_pkg;

   localparam int ADR_W = 8;
   localparam int DAT_W = 8;

   // Bus request driven by the controller.
   typedef struct packed {
      logic [ADR_W-1:0] adr;
      logic [DAT_W-1:0] dat;
      logic             we;
      logic             stb;
   } iWishbone_Ctrl;

   // Bus response returned by the addressed peripheral.
   typedef struct packed {
      logic [DAT_W-1:0] dat;
      logic             ack;
   } iWishbone_Peri;

   // Controller FSM states.
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GET_DATA = 2'd1,
      BUS      = 2'd2,
      RESP     = 2'd3
   } state_e;

   // Command byte layout: bit7 = write enable, bits3:0 = address.
   localparam int CMD_WE_BIT  = 7;
   localparam int CMD_ADR_MSB = 3;

   // Byte returned for a read that was abandoned without ack.
   localparam logic [7:0] ERR_BYTE_DFLT = 8'hEE;

   // Extract the address field of a command byte, zero-extended to ADR_W.
   function automatic logic [ADR_W-1:0] cmd_adr(input logic [7:0] cmd);
      logic [ADR_W-1:0] adr;
      adr = {ADR_W{1'b0}};
      adr[CMD_ADR_MSB:0] = cmd[CMD_ADR_MSB:0];
      return adr;
   endfunction

endpackage

// File: rtl/byte_wb_ctrl_if.sv
//------------------------------------------------------------------------------
// byte_wb_ctrl_if
// Groups the receive byte stream, transmit byte stream and Wishbone bus of the
// controller. The 'master' modport is the controller side (it masters the
// Wishbone bus); the 'slave' modport is the environment side (receiver,
// transmitter and peripherals).
//------------------------------------------------------------------------------
interface byte_wb_ctrl_if;
   import byte_wb_pkg::*;

   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;

   logic [7:0]    tx_data;
   logic          tx_valid;
   logic          tx_ready;

   iWishbone_Ctrl wb_c;
   iWishbone_Peri wb_p;

   modport master (
      input  rx_data, rx_valid, tx_ready, wb_p,
      output rx_ready, tx_data, tx_valid, wb_c
   );

   modport slave (
      output rx_data, rx_valid, tx_ready, wb_p,
      input  rx_ready, tx_data, tx_valid, wb_c
   );

endinterface

// File: rtl/byte_wb_ctrl.sv
//------------------------------------------------------------------------------
// byte_wb_ctrl
// Turns a command byte stream into single Wishbone transactions, one in
// flight at a time. A command byte carries we (bit7) and adr (bits3:0); a
// write command is followed by one data byte. Read results are returned as a
// single byte on the transmit stream.
//
// Optional feature: define BYTE_WB_CTRL_TIMEOUT_EN to abandon a bus cycle
// after TIMEOUT cycles without ack (reads then return ERR_BYTE). Without it
// the bus cycle waits for ack indefinitely.
//
// All outputs are registered; their next values are decoded from the next
// state so that stb, rx_ready and tx_valid always track the FSM exactly.
//------------------------------------------------------------------------------
module byte_wb_ctrl
   import byte_wb_pkg::*;
#(
   parameter int         TIMEOUT  = 255,
   parameter logic [7:0] ERR_BYTE = ERR_BYTE_DFLT
)(
   input  logic            clk,
   input  logic            rst_n,
   byte_wb_ctrl_if.master  bus
);

   localparam logic [1:0] ST_IDLE     = IDLE;
   localparam logic [1:0] ST_GET_DATA = GET_DATA;
   localparam logic [1:0] ST_BUS      = BUS;
   localparam logic [1:0] ST_RESP     = RESP;

   logic [1:0]       state_q,    state_d;
   logic             rx_ready_q, rx_ready_d;
   logic             tx_valid_q, tx_valid_d;
   logic [7:0]       tx_data_q,  tx_data_d;
   logic             stb_q,      stb_d;
   logic             we_q,       we_d;
   logic [ADR_W-1:0] adr_q,      adr_d;
   logic [DAT_W-1:0] dat_q,      dat_d;

   logic rx_fire_s;
   logic tx_fire_s;
   logic ack_s;
   logic tmo_s;

   assign rx_fire_s = bus.rx_valid && rx_ready_q;
   assign tx_fire_s = tx_valid_q && bus.tx_ready;
   // ack only counts while a bus cycle is actually open
   assign ack_s     = bus.wb_p.ack && (state_q == ST_BUS);

`ifdef BYTE_WB_CTRL_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] wait_q, wait_d;

   // Wait counter: zero outside BUS, counts BUS cycles that see no ack.
   always_comb begin
      wait_d = wait_q;
      if (state_q != ST_BUS) begin
         wait_d = 8'd0;
      end else if (!bus.wb_p.ack) begin
         wait_d = wait_q + 8'd1;
      end else begin
         wait_d = wait_q;
      end
   end

   // Wait counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_q <= 8'd0;
      end else begin
         wait_q <= wait_d;
      end
   end

   // Last permitted cycle without ack; ack in the same cycle takes priority.
   assign tmo_s = (state_q == ST_BUS) && !bus.wb_p.ack && (wait_q == TMO_LAST);
`else
   logic [39:0] cfg_unused_s;

   assign tmo_s        = 1'b0;
   assign cfg_unused_s = {32'(TIMEOUT), ERR_BYTE};
`endif

   // Next-state and datapath decode for the command FSM.
   always_comb begin
      state_d   = state_q;
      tx_data_d = tx_data_q;
      we_d      = we_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      case (state_q)
         ST_IDLE: begin
            if (rx_fire_s) begin
               we_d  = bus.rx_data[CMD_WE_BIT];
               adr_d = cmd_adr(bus.rx_data);
               if (bus.rx_data[CMD_WE_BIT]) begin
                  state_d = ST_GET_DATA;
               end else begin
                  state_d = ST_BUS;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GET_DATA: begin
            if (rx_fire_s) begin
               dat_d   = bus.rx_data;
               state_d = ST_BUS;
            end else begin
               state_d = ST_GET_DATA;
            end
         end
         ST_BUS: begin
            if (ack_s) begin
               if (we_q) begin
                  state_d = ST_IDLE;
               end else begin
                  tx_data_d = bus.wb_p.dat;
                  state_d   = ST_RESP;
               end
            end else if (tmo_s) begin
               if (we_q) begin
                  state_d = ST_IDLE;
               end else begin
                  tx_data_d = ERR_BYTE;
                  state_d   = ST_RESP;
               end
            end else begin
               state_d = ST_BUS;
            end
         end
         ST_RESP: begin
            if (tx_fire_s) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered handshake/strobe outputs follow the state being entered.
   always_comb begin
      rx_ready_d = (state_d == ST_IDLE) || (state_d == ST_GET_DATA);
      stb_d      = (state_d == ST_BUS);
      tx_valid_d = (state_d == ST_RESP);
   end

   // State and output registers; reset applies asynchronously.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         rx_ready_q <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 8'h00;
         stb_q      <= 1'b0;
         we_q       <= 1'b0;
         adr_q      <= {ADR_W{1'b0}};
         dat_q      <= {DAT_W{1'b0}};
      end else begin
         state_q    <= state_d;
         rx_ready_q <= rx_ready_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         stb_q      <= stb_d;
         we_q       <= we_d;
         adr_q      <= adr_d;
         dat_q      <= dat_d;
      end
   end

   assign bus.rx_ready = rx_ready_q;
   assign bus.tx_valid = tx_valid_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.wb_c     = {adr_q, dat_q, we_q, stb_q};

endmodule

// File: tb/tb_byte_wb_ctrl.sv
//------------------------------------------------------------------------------
// tb_byte_wb_ctrl
// Directed bench for byte_wb_ctrl. Stimulus pushes expected bus transactions
// and response bytes into queues; independent monitors pop and compare when
// the DUT completes a bus cycle or a transmit handshake.
//------------------------------------------------------------------------------
module tb_byte_wb_ctrl;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;

   always #5 clk = ~clk;

   byte_wb_ctrl_if bus ();

   byte_wb_ctrl #(
      .TIMEOUT  (8),
      .ERR_BYTE (8'hEE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- peripheral model ----------------
   logic [7:0] mem [16] = '{8'h00, 8'h00, 8'h3C, 8'hA7, 8'h96, 8'h00, 8'h00, 8'h00,
                            8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
   int   wait_cfg = 0;
   int   wcnt     = 0;
   logic ack_s;

   assign ack_s = bus.wb_c.stb && (wcnt >= wait_cfg);

   always_comb begin
      bus.wb_p.dat = mem[bus.wb_c.adr[3:0]];
      bus.wb_p.ack = ack_s;
   end

   always @(posedge clk) begin
      if (!bus.wb_c.stb || ack_s) wcnt <= 0;
      else                        wcnt <= wcnt + 1;
      if (bus.wb_c.stb && ack_s && bus.wb_c.we) mem[bus.wb_c.adr[3:0]] <= bus.wb_c.dat;
   end

   // ---------------- scoreboard queues ----------------
   typedef struct {
      logic [7:0] adr;
      logic       we;
      logic [7:0] dat;
      int         len;
   } wb_exp_t;

   wb_exp_t    wb_q [$];
   logic [7:0] tx_q [$];

   task automatic exp_wb(input logic [7:0] adr, input logic we, input logic [7:0] dat, input int len);
      wb_exp_t e;
      e.adr = adr; e.we = we; e.dat = dat; e.len = len;
      wb_q.push_back(e);
   endtask

   // ---------------- bus monitor ----------------
   int      stb_len = 0;
   wb_exp_t we_cur;

   always @(negedge clk) begin
      if (!bus.wb_c.stb) begin
         stb_len = 0;
      end else begin
         stb_len = stb_len + 1;
         chk("rx_ready_in_bus", 32'(bus.rx_ready), 32'd0);
         if (bus.wb_p.ack) begin
            if (wb_q.size() == 0) begin
               chk("unexpected_wb_cycle", 32'd1, 32'd0);
            end else begin
               we_cur = wb_q.pop_front();
               chk("wb_adr", 32'(bus.wb_c.adr), 32'(we_cur.adr));
               chk("wb_we",  32'(bus.wb_c.we),  32'(we_cur.we));
               if (we_cur.we) chk("wb_dat", 32'(bus.wb_c.dat), 32'(we_cur.dat));
               chk("stb_len", 32'(stb_len), 32'(we_cur.len));
            end
         end
      end
   end

   // ---------------- transmit monitor ----------------
   logic       stall_q   = 1'b0;
   logic [7:0] stall_dat = 8'h00;
   logic [7:0] tx_exp;

   always @(negedge clk) begin
      if (stall_q) begin
         chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
         chk("tx_hold_data",  32'(bus.tx_data),  32'(stall_dat));
      end
      if (bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            chk("unexpected_tx_byte", 32'd1, 32'd0);
         end else begin
            tx_exp = tx_q.pop_front();
            chk("tx_data", 32'(bus.tx_data), 32'(tx_exp));
         end
      end
      stall_q   = bus.tx_valid && !bus.tx_ready && rst_n;
      stall_dat = bus.tx_data;
   end

   // ---------------- stimulus helpers ----------------
   // Present a byte and hold it until accepted; returns 1 time unit after the
   // accepting edge. Must be called away from a rising edge.
   task automatic send_byte(input logic [7:0] b);
      int   n;
      logic rdy;
      n = 0;
      bus.rx_data  = b;
      bus.rx_valid = 1'b1;
      forever begin
         rdy = bus.rx_ready;
         @(posedge clk);
         if (rdy) break;
         n++;
         if (n > 200) begin
            chk("rx_accept_timeout", 32'd1, 32'd0);
            break;
         end
         #1;
      end
      #1;
      bus.rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'h00;
      bus.tx_ready = 1'b1;
      #2 rst_n = 1'b0;
      idle(2);
      chk("rst_rx_ready", 32'(bus.rx_ready),   32'd0);
      chk("rst_tx_valid", 32'(bus.tx_valid),   32'd0);
      chk("rst_tx_data",  32'(bus.tx_data),    32'd0);
      chk("rst_stb",      32'(bus.wb_c.stb),   32'd0);
      chk("rst_we",       32'(bus.wb_c.we),    32'd0);
      chk("rst_adr",      32'(bus.wb_c.adr),   32'd0);
      chk("rst_dat",      32'(bus.wb_c.dat),   32'd0);
      rst_n = 1'b1;
      idle(1);
      chk("idle_rx_ready", 32'(bus.rx_ready), 32'd1);

      // Write 0x5A to adr 1, combinational ack
      exp_wb(8'h01, 1'b1, 8'h5A, 1);
      send_byte(8'h81);
      send_byte(8'h5A);
      chk("wr_stb_next_cycle", 32'(bus.wb_c.stb), 32'd1);
      idle(3);
      chk("wr_mem1", 32'(mem[1]), 32'h5A);
      chk("wr_hold_adr", 32'(bus.wb_c.adr), 32'h01);
      chk("wr_hold_dat", 32'(bus.wb_c.dat), 32'h5A);

      // Read adr 2, zero-wait: tx_valid rises one edge after the bus cycle
      exp_wb(8'h02, 1'b0, 8'h00, 1);
      tx_q.push_back(8'h3C);
      send_byte(8'h02);
      chk("rd_tx_valid_early", 32'(bus.tx_valid), 32'd0);
      @(posedge clk); #1;
      chk("rd_tx_valid_lat", 32'(bus.tx_valid), 32'd1);
      chk("rd_tx_data_lat",  32'(bus.tx_data),  32'h3C);
      idle(3);

      // Read adr 3 with 5 wait states; reserved bits 6:4 set
      wait_cfg = 5;
      exp_wb(8'h03, 1'b0, 8'h00, 6);
      tx_q.push_back(8'hA7);
      send_byte(8'h73);
      idle(12);
      wait_cfg = 0;

      // Transmitter backpressure with the next command already waiting
      bus.tx_ready = 1'b0;
      exp_wb(8'h04, 1'b0, 8'h00, 1);
      tx_q.push_back(8'h96);
      send_byte(8'h04);
      bus.rx_data  = 8'h85;
      bus.rx_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_rx_ready", 32'(bus.rx_ready), 32'd0);
      end
      chk("bp_tx_valid", 32'(bus.tx_valid), 32'd1);
      bus.tx_ready = 1'b1;
      exp_wb(8'h05, 1'b1, 8'h11, 1);
      send_byte(8'h85);
      send_byte(8'h11);
      idle(3);
      chk("bp_wr_mem5", 32'(mem[5]), 32'h11);

      // Asynchronous reset in the middle of a stalled bus cycle
      wait_cfg = 100;
      send_byte(8'h06);
      @(posedge clk); #3;
      chk("pre_rst_stb", 32'(bus.wb_c.stb), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("arst_stb",      32'(bus.wb_c.stb), 32'd0);
      chk("arst_tx_valid", 32'(bus.tx_valid), 32'd0);
      chk("arst_rx_ready", 32'(bus.rx_ready), 32'd0);
      chk("arst_adr",      32'(bus.wb_c.adr), 32'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      wait_cfg = 0;
      idle(1);
      chk("post_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      exp_wb(8'h01, 1'b1, 8'hFF, 1);
      send_byte(8'h81);
      send_byte(8'hFF);
      idle(3);
      chk("post_rst_mem1", 32'(mem[1]), 32'hFF);
      exp_wb(8'h01, 1'b0, 8'h00, 1);
      tx_q.push_back(8'hFF);
      send_byte(8'h01);
      idle(4);

`ifdef BYTE_WB_CTRL_TIMEOUT_EN
      // Read with no ack: abandoned after 8 strobe cycles, returns 0xEE
      wait_cfg = 1000;
      tx_q.push_back(8'hEE);
      send_byte(8'h07);
      n = 0;
      @(negedge clk);
      while (bus.wb_c.stb && n < 50) begin
         n++;
         @(negedge clk);
      end
      chk("tmo_stb_len", 32'(n), 32'd8);
      idle(4);
      wait_cfg = 0;
`else
      n = 0;
`endif

      chk("wb_queue_drained", 32'(wb_q.size()), 32'd0);
      chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   // Global time bound
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

endmodule
